stonyman_scan_sequencer: RTL and testbench
==========================================

Name: stonyman_scan_sequencer

Overview:
- Frame-level scheduler for the Stonyman imager and its serial-ADC capture controller.
- Walks the pixel array row by row by pulsing the imager's resv/incv/resp/incp pointer lines.
- At each pixel, lets the analog output settle, then issues a one-cycle capture request to the ADC controller.
- Advances to the next pixel as soon as the ADC controller reports `adc_capture_done` (end of track), so addressing overlaps with conversion.

Parameters:
- ROWS, 112, pixel rows per frame (1..255).
- COLS, 112, pixel columns per row (1..255).
- PULSE_CYCLES, 2, clk cycles each pointer pulse is high; followed by an equal low gap (1..255).
- SETTLE_CYCLES, 4, clk cycles between end of addressing and capture request (1..255).
- DONE_TIMEOUT, 200, max clk cycles waiting for adc_capture_done before aborting the frame (1..255).

Ports:
- clk  in  1  system clock (40 MHz domain)
- reset  in  1  synchronous, active-high reset
- frame_start  in  1  request a full-frame scan; sampled only in IDLE
- frame_abort  in  1  stop current frame immediately
- adc_capture_done  in  1  from ADC controller, 1-cycle pulse at end of track
- adc_capture_start  out  1  to ADC controller, 1-cycle capture request
- resv  out  1  imager vertical-pointer reset pulse
- incv  out  1  imager vertical-pointer increment pulse
- resp  out  1  imager horizontal-pointer reset pulse
- incp  out  1  imager horizontal-pointer increment pulse
- row_idx  out  8  current row address
- col_idx  out  8  current column address
- busy  out  1  high whenever state is not IDLE
- frame_done  out  1  1-cycle pulse on normal frame completion
- frame_error  out  1  sticky timeout flag; cleared by next accepted frame_start or reset

Behaviour:
- Clock and reset:
  - Single clock `clk`. Reset is synchronous, active-high, on `reset`.
  - Reset values: all outputs 0, `row_idx` = `col_idx` = 0, state IDLE, timer 0.
  - Reset asserted mid-frame forces all pulse lines low on the next edge.
- All outputs are registered.
- 8-bit down-counter timer.
- States:
  - IDLE: `busy` = 0. On `frame_start`: clear `frame_error`, set `row_idx` = `col_idx` = 0, go to RESV.
  - RESV: `resv` high PULSE_CYCLES, then low PULSE_CYCLES; go to RESP.
  - RESP: `resp` high PULSE_CYCLES, then low PULSE_CYCLES; `col_idx` = 0; go to SETTLE.
  - SETTLE: count SETTLE_CYCLES; go to CAPTURE.
  - CAPTURE: `adc_capture_start` = 1 for exactly one cycle; load timer = DONE_TIMEOUT; go to WAIT_DONE.
  - WAIT_DONE: on `adc_capture_done`:
    - col_idx < COLS-1: go to INCP.
    - else row_idx < ROWS-1: go to INCV.
    - else: go to DONE.
    - On timer expiry with no done: set `frame_error`, go to IDLE with no `frame_done`.
  - INCP: `incp` high PULSE_CYCLES, low PULSE_CYCLES; `col_idx` +1 on exit; go to SETTLE.
  - INCV: `incv` high PULSE_CYCLES, low PULSE_CYCLES; `row_idx` +1 on exit; go to RESP.
  - DONE: `frame_done` = 1 for one cycle; go to IDLE.
- Pulse rules:
  - Only one of resv/incv/resp/incp is high in any cycle.
  - Every pulse is exactly PULSE_CYCLES wide with a PULSE_CYCLES low gap after it.
- `adc_capture_done` outside WAIT_DONE is ignored, including done arriving in the CAPTURE cycle.
- `frame_start` while busy is ignored and not queued.
- `frame_abort`:
  - In any non-IDLE state: next cycle IDLE, all pulse lines low, no `frame_done`, `frame_error` unchanged.
  - Abort wins over a coincident `adc_capture_done`.
- Per frame the sequencer issues:
  - 1 resv pulse, ROWS resp pulses, ROWS×(COLS-1) incp pulses, ROWS-1 incv pulses, ROWS×COLS capture requests.
- `row_idx`/`col_idx` are stable from SETTLE entry through WAIT_DONE of each pixel.
- `row_idx`/`col_idx` hold their last values after DONE, abort, or timeout.

Test Plan:
- ROWS=3, COLS=4, PULSE=1, SETTLE=2; model returns done 14 cycles after each start -> 1 resv, 3 resp, 9 incp, 2 incv, 12 capture starts; pixel order (0,0)…(2,3); one frame_done; busy low after.
- PULSE=3 -> every resv/resp/incp/incv high exactly 3 cycles, low ≥3 before next pulse; never two lines high together; start-to-first-capture = 3+3 + 3+3 + SETTLE cycles.
- DONE_TIMEOUT=10, model never answers on pixel (1,2) -> frame_error=1 after 10 WAIT_DONE cycles, no frame_done, IDLE; next frame_start clears frame_error.
- frame_start pulsed repeatedly during a frame -> ignored, exactly one frame completes; capture_done injected during SETTLE -> no advance.
- frame_abort coincident with capture_done at pixel (0,1) -> IDLE next cycle, pulse lines 0, no frame_done, indices hold (0,1).
- reset asserted while incp high -> next cycle all outputs 0, state IDLE; fresh frame_start runs a full correct frame.

Source files
------------

// File: rtl/stonyman_scan_sequencer.sv
// stonyman_scan_sequencer
//
// Frame-level scheduler for the Stonyman imager and its serial-ADC capture
// controller. Walks the pixel array row by row by pulsing the imager pointer
// lines, lets the analog output settle at each pixel, requests one ADC
// capture, and moves on as soon as the ADC reports end of track so that
// addressing of the next pixel overlaps with conversion of the current one.
//
// Ports:
//   clk               system clock
//   reset             synchronous, active-high reset
//   frame_start       request a full-frame scan (accepted only when idle)
//   frame_abort       stop the current frame immediately
//   adc_capture_done  1-cycle end-of-track pulse from the ADC controller
//   adc_capture_start 1-cycle capture request to the ADC controller
//   resv / incv       vertical-pointer reset / increment pulses
//   resp / incp       horizontal-pointer reset / increment pulses
//   row_idx, col_idx  address of the pixel being scanned
//   busy              high whenever a frame is in progress
//   frame_done        1-cycle pulse on normal frame completion
//   frame_error       sticky capture-timeout flag
//
// All outputs are registered: each is decoded from the next-state values so
// that it lines up exactly with the state register.

module stonyman_scan_sequencer #(
  parameter int ROWS          = 112,
  parameter int COLS          = 112,
  parameter int PULSE_CYCLES  = 2,
  parameter int SETTLE_CYCLES = 4,
  parameter int DONE_TIMEOUT  = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_start,
  input  logic       frame_abort,
  input  logic       adc_capture_done,
  output logic       adc_capture_start,
  output logic       resv,
  output logic       incv,
  output logic       resp,
  output logic       incp,
  output logic [7:0] row_idx,
  output logic [7:0] col_idx,
  output logic       busy,
  output logic       frame_done,
  output logic       frame_error
);

  // The down-counter is loaded with N-1 so that a state lasts exactly N cycles.
  localparam logic [7:0] PULSE_LOAD  = 8'(PULSE_CYCLES - 1);
  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] DONE_LOAD   = 8'(DONE_TIMEOUT - 1);
  localparam logic [7:0] LAST_ROW    = 8'(ROWS - 1);
  localparam logic [7:0] LAST_COL    = 8'(COLS - 1);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RESV,
    ST_RESP,
    ST_SETTLE,
    ST_CAPTURE,
    ST_WAIT_DONE,
    ST_INCP,
    ST_INCV,
    ST_DONE
  } state_e;

  state_e     state_q, state_d;
  logic       phase_q, phase_d;
  logic [7:0] timer_q, timer_d;
  logic [7:0] row_idx_q, row_idx_d;
  logic [7:0] col_idx_q, col_idx_d;
  logic       frame_error_q, frame_error_d;
  logic       resv_q, resv_d;
  logic       incv_q, incv_d;
  logic       resp_q, resp_d;
  logic       incp_q, incp_d;
  logic       capture_q, capture_d;
  logic       busy_q, busy_d;
  logic       frame_done_q, frame_done_d;

  // A pointer-pulse state has two halves: phase 0 drives the line high,
  // phase 1 is the equal-length low gap. The state is left only when the
  // low half has run out.
  logic pulse_last;
  assign pulse_last = (timer_q == 8'd0) && phase_q;

  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    timer_d       = timer_q;
    row_idx_d     = row_idx_q;
    col_idx_d     = col_idx_q;
    frame_error_d = frame_error_q;

    if ((state_q == ST_RESV) || (state_q == ST_RESP) ||
        (state_q == ST_INCP) || (state_q == ST_INCV)) begin
      if (timer_q != 8'd0) begin
        timer_d = timer_q - 8'd1;
      end else if (!phase_q) begin
        phase_d = 1'b1;
        timer_d = PULSE_LOAD;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          frame_error_d = 1'b0;
          row_idx_d     = 8'd0;
          col_idx_d     = 8'd0;
          state_d       = ST_RESV;
          phase_d       = 1'b0;
          timer_d       = PULSE_LOAD;
        end
      end
      ST_RESV: begin
        if (pulse_last) begin
          state_d = ST_RESP;
          phase_d = 1'b0;
          timer_d = PULSE_LOAD;
        end
      end
      ST_RESP: begin
        col_idx_d = 8'd0;
        if (pulse_last) begin
          state_d = ST_SETTLE;
          timer_d = SETTLE_LOAD;
        end
      end
      ST_SETTLE: begin
        if (timer_q == 8'd0) begin
          state_d = ST_CAPTURE;
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end
      ST_CAPTURE: begin
        state_d = ST_WAIT_DONE;
        timer_d = DONE_LOAD;
      end
      ST_WAIT_DONE: begin
        if (adc_capture_done) begin
          phase_d = 1'b0;
          timer_d = PULSE_LOAD;
          if (col_idx_q < LAST_COL) begin
            state_d = ST_INCP;
          end else if (row_idx_q < LAST_ROW) begin
            state_d = ST_INCV;
          end else begin
            state_d = ST_DONE;
          end
        end else if (timer_q == 8'd0) begin
          frame_error_d = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end
      ST_INCP: begin
        if (pulse_last) begin
          col_idx_d = col_idx_q + 8'd1;
          state_d   = ST_SETTLE;
          timer_d   = SETTLE_LOAD;
        end
      end
      ST_INCV: begin
        if (pulse_last) begin
          row_idx_d = row_idx_q + 8'd1;
          state_d   = ST_RESP;
          phase_d   = 1'b0;
          timer_d   = PULSE_LOAD;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort overrides everything, including a coincident capture-done, and
    // leaves the indices and the error flag exactly as they were.
    if (frame_abort && (state_q != ST_IDLE)) begin
      state_d       = ST_IDLE;
      phase_d       = 1'b0;
      timer_d       = 8'd0;
      row_idx_d     = row_idx_q;
      col_idx_d     = col_idx_q;
      frame_error_d = frame_error_q;
    end

    resv_d       = (state_d == ST_RESV) && !phase_d;
    resp_d       = (state_d == ST_RESP) && !phase_d;
    incp_d       = (state_d == ST_INCP) && !phase_d;
    incv_d       = (state_d == ST_INCV) && !phase_d;
    capture_d    = (state_d == ST_CAPTURE);
    frame_done_d = (state_d == ST_DONE);
    busy_d       = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      phase_q       <= 1'b0;
      timer_q       <= 8'd0;
      row_idx_q     <= 8'd0;
      col_idx_q     <= 8'd0;
      frame_error_q <= 1'b0;
      resv_q        <= 1'b0;
      incv_q        <= 1'b0;
      resp_q        <= 1'b0;
      incp_q        <= 1'b0;
      capture_q     <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      timer_q       <= timer_d;
      row_idx_q     <= row_idx_d;
      col_idx_q     <= col_idx_d;
      frame_error_q <= frame_error_d;
      resv_q        <= resv_d;
      incv_q        <= incv_d;
      resp_q        <= resp_d;
      incp_q        <= incp_d;
      capture_q     <= capture_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign adc_capture_start = capture_q;
  assign resv              = resv_q;
  assign incv              = incv_q;
  assign resp              = resp_q;
  assign incp              = incp_q;
  assign row_idx           = row_idx_q;
  assign col_idx           = col_idx_q;
  assign busy              = busy_q;
  assign frame_done        = frame_done_q;
  assign frame_error       = frame_error_q;

endmodule

// File: tb/tb_stonyman_scan_sequencer.sv
// Self-checking bench for stonyman_scan_sequencer on a small 3x4 array.
// Expected pixel addresses are queued when a frame is started and popped
// each time the sequencer issues a capture request; pulse widths, gaps and
// per-frame pulse counts are derived from the parameters below.

module tb_stonyman_scan_sequencer;

  localparam int ROWS       = 3;
  localparam int COLS       = 4;
  localparam int PULSE      = 3;
  localparam int SETTLE     = 2;
  localparam int TIMEOUT    = 20;
  localparam int DONE_DELAY = 14;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_start;
  logic       frame_abort;
  logic       model_done = 1'b0;
  logic       inject_done;
  logic       adc_capture_done;
  logic       adc_capture_start;
  logic       resv, incv, resp, incp;
  logic [7:0] row_idx, col_idx;
  logic       busy, frame_done, frame_error;

  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_q[$];
  int          rise_cnt[4] = '{0, 0, 0, 0};
  int          base_rise[4];
  int          run_len[4] = '{0, 0, 0, 0};
  int          cap_cnt = 0;
  int          fdone_cnt = 0;
  int          base_cap, base_fd;
  int          quiet = 1000;
  int          model_cnt = 0;
  logic [3:0]  lines_prev = 4'b0;
  logic        rst_at_edge = 1'b0;
  logic        model_on, mute_on;
  logic [7:0]  mute_row, mute_col;

  always #5 clk = ~clk;

  // The ADC-side done line is the model's answer ORed with hand-injected pulses.
  assign adc_capture_done = model_done | inject_done;

  stonyman_scan_sequencer #(
    .ROWS(ROWS), .COLS(COLS), .PULSE_CYCLES(PULSE),
    .SETTLE_CYCLES(SETTLE), .DONE_TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .frame_abort(frame_abort),
    .adc_capture_done(adc_capture_done), .adc_capture_start(adc_capture_start),
    .resv(resv), .incv(incv), .resp(resp), .incp(incp),
    .row_idx(row_idx), .col_idx(col_idx), .busy(busy),
    .frame_done(frame_done), .frame_error(frame_error)
  );

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Queues the expected pixel order for the frame and pulses frame_start once.
  task automatic applyStimulus(input int n_pix);
    for (int p = 0; p < n_pix; p++) begin
      exp_q.push_back({8'(p / COLS), 8'(p % COLS)});
    end
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  // Remembers the monitor counters so per-frame deltas can be checked later.
  task automatic takeSnapshot();
    for (int i = 0; i < 4; i++) base_rise[i] = rise_cnt[i];
    base_cap = cap_cnt;
    base_fd  = fdone_cnt;
  endtask

  // Compares pulse/capture/done counts accumulated since the last snapshot.
  task automatic checkCounts(input string tag, input int e_resv, input int e_resp,
                             input int e_incp, input int e_incv, input int e_cap,
                             input int e_fd);
    checkOutput({tag, "_resv"}, rise_cnt[3] - base_rise[3], e_resv);
    checkOutput({tag, "_resp"}, rise_cnt[1] - base_rise[1], e_resp);
    checkOutput({tag, "_incp"}, rise_cnt[0] - base_rise[0], e_incp);
    checkOutput({tag, "_incv"}, rise_cnt[2] - base_rise[2], e_incv);
    checkOutput({tag, "_captures"}, cap_cnt - base_cap, e_cap);
    checkOutput({tag, "_frame_done"}, fdone_cnt - base_fd, e_fd);
    checkOutput({tag, "_queue_left"}, exp_q.size(), 0);
  endtask

  // Waits (bounded) for the sequencer to fall back to idle.
  task automatic waitIdle(input string tag, input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy) checkOutput(tag, int'(busy), 0);
  endtask

  // Waits (bounded) for the next capture request.
  task automatic waitCapture(input string tag, input int budget);
    int n;
    n = 0;
    while (!adc_capture_start && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!adc_capture_start) checkOutput(tag, int'(adc_capture_start), 1);
  endtask

  // Tracks whether reset was applied at the last active edge, so a pulse
  // truncated by reset is not mistaken for a bad pulse width.
  always @(posedge clk) begin
    rst_at_edge = reset;
  end

  // Monitor and ADC model, sampled mid-cycle: pulse width/gap/exclusivity,
  // pulse counts, scoreboard pop on every capture, and the delayed done answer.
  always @(negedge clk) begin : monitor
    logic [3:0] lines;
    lines = {resv, incv, resp, incp};
    if (|lines) checkOutput("pulse_onehot", int'($onehot(lines)), 1);
    for (int i = 0; i < 4; i++) begin
      if (lines[i]) begin
        if (!lines_prev[i]) begin
          rise_cnt[i]++;
          checkOutput("pulse_gap_ok", int'(quiet >= PULSE), 1);
        end
        run_len[i]++;
      end else if (lines_prev[i]) begin
        if (!rst_at_edge) checkOutput("pulse_width", run_len[i], PULSE);
        run_len[i] = 0;
      end
    end
    if (rst_at_edge) quiet = 1000;
    else if (|lines) quiet = 0;
    else if (quiet < 1000) quiet++;
    lines_prev = lines;

    if (adc_capture_start) begin
      cap_cnt++;
      if (exp_q.size() == 0) checkOutput("cap_pixel_unexpected", int'({row_idx, col_idx}), -1);
      else checkOutput("cap_pixel", int'({row_idx, col_idx}), int'(exp_q.pop_front()));
    end
    if (frame_done) fdone_cnt++;

    model_done = 1'b0;
    if (model_cnt > 0) begin
      model_cnt--;
      if (model_cnt == 0) model_done = 1'b1;
    end
    if (adc_capture_start && model_on &&
        !(mute_on && row_idx == mute_row && col_idx == mute_col)) begin
      model_cnt = DONE_DELAY;
    end
  end

  // Hard stop in case something wedges outside the bounded waits.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, failures so far %0d", failures);
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence: reset, normal frame with nuisance inputs, timeout frame,
  // abort frame, reset mid-pulse, and a clean frame after reset.
  initial begin
    int  n;
    int  t;
    bit  seen;
    reset       = 1'b1;
    frame_start = 1'b0;
    frame_abort = 1'b0;
    inject_done = 1'b0;
    model_on    = 1'b1;
    mute_on     = 1'b0;
    mute_row    = 8'd1;
    mute_col    = 8'd2;
    repeat (3) @(negedge clk);

    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_lines", int'({resv, incv, resp, incp, adc_capture_start}), 0);
    checkOutput("rst_row", int'(row_idx), 0);
    checkOutput("rst_col", int'(col_idx), 0);
    checkOutput("rst_flags", int'({frame_done, frame_error}), 0);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] frame A: normal scan with stray starts and stray dones");
    takeSnapshot();
    applyStimulus(ROWS * COLS);
    n = 1;
    while (!adc_capture_start && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("start_to_capture", n - 1, 4 * PULSE + SETTLE);
    inject_done = 1'b1;
    @(negedge clk);
    inject_done = 1'b0;
    n = 0;
    while (!incp && n < 200) begin
      @(negedge clk);
      n++;
    end
    while (incp && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (PULSE) @(negedge clk);
    inject_done = 1'b1;
    @(negedge clk);
    inject_done = 1'b0;
    n = 0;
    while (busy && n < 3000) begin
      if (n % 40 == 5) frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      n++;
    end
    if (busy) checkOutput("frameA_end", int'(busy), 0);
    repeat (4) @(negedge clk);
    checkOutput("frameA_stays_idle", int'(busy), 0);
    checkCounts("frameA", 1, ROWS, ROWS * (COLS - 1), ROWS - 1, ROWS * COLS, 1);
    checkOutput("frameA_row_hold", int'(row_idx), ROWS - 1);
    checkOutput("frameA_col_hold", int'(col_idx), COLS - 1);
    checkOutput("frameA_error", int'(frame_error), 0);

    $display("[TB] frame B: ADC silent on pixel (1,2)");
    mute_on = 1'b1;
    takeSnapshot();
    applyStimulus(COLS + 3);
    seen = 1'b0;
    t = 0;
    n = 0;
    while (busy && n < 3000) begin
      if (seen) t++;
      if (adc_capture_start && row_idx == 8'd1 && col_idx == 8'd2) seen = 1'b1;
      @(negedge clk);
      n++;
    end
    checkOutput("timeout_wait_cycles", t, TIMEOUT);
    checkOutput("timeout_busy", int'(busy), 0);
    checkOutput("timeout_error", int'(frame_error), 1);
    repeat (3) @(negedge clk);
    checkCounts("frameB", 1, 2, (COLS - 1) + 2, 1, COLS + 3, 0);
    mute_on = 1'b0;

    $display("[TB] frame C: abort coincident with done at pixel (0,1)");
    model_on = 1'b0;
    takeSnapshot();
    applyStimulus(2);
    checkOutput("error_cleared", int'(frame_error), 0);
    waitCapture("frameC_cap0_wait", 500);
    repeat (3) @(negedge clk);
    inject_done = 1'b1;
    @(negedge clk);
    inject_done = 1'b0;
    waitCapture("frameC_cap1_wait", 500);
    repeat (3) @(negedge clk);
    inject_done = 1'b1;
    frame_abort = 1'b1;
    @(negedge clk);
    inject_done = 1'b0;
    frame_abort = 1'b0;
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_lines", int'({resv, incv, resp, incp, adc_capture_start}), 0);
    checkOutput("abort_row", int'(row_idx), 0);
    checkOutput("abort_col", int'(col_idx), 1);
    checkOutput("abort_frame_done", int'(frame_done), 0);
    repeat (3) @(negedge clk);
    checkCounts("frameC", 1, 1, 1, 0, 2, 0);

    $display("[TB] frame D: reset while incp is high");
    model_on = 1'b1;
    takeSnapshot();
    applyStimulus(1);
    n = 0;
    while (!incp && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!incp) checkOutput("frameD_incp_wait", int'(incp), 1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midrst_busy", int'(busy), 0);
    checkOutput("midrst_lines", int'({resv, incv, resp, incp, adc_capture_start}), 0);
    checkOutput("midrst_idx", int'({row_idx, col_idx}), 0);
    checkOutput("midrst_flags", int'({frame_done, frame_error}), 0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("frameD_queue_left", exp_q.size(), 0);

    $display("[TB] frame E: full frame after reset");
    takeSnapshot();
    applyStimulus(ROWS * COLS);
    waitIdle("frameE_end", 3000);
    repeat (3) @(negedge clk);
    checkCounts("frameE", 1, ROWS, ROWS * (COLS - 1), ROWS - 1, ROWS * COLS, 1);
    checkOutput("frameE_row_hold", int'(row_idx), ROWS - 1);
    checkOutput("frameE_col_hold", int'(col_idx), COLS - 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
